// File: rtl/fifo_pkg.sv
// Shared constants and flag bundle for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATASIZE = 8;
  localparam int unsigned FIFO_ADDRSIZE = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_mem.sv
// DEPTH x DATASIZE storage: write-enabled port plus a registered, resettable read port.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = FIFO_DATASIZE,
  parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int unsigned Depth = 32'd1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [Depth];

  // Storage is deliberately not reset; stale words are unreachable after pointer reset.
  always_ff @(posedge wclk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with binary wrap-bit pointers, occupancy count and almost flags.
// Optional sticky woverflow/runderflow outputs when FIFO_SYNC_ERR_EN is defined.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE   = FIFO_DATASIZE,
  parameter int unsigned ADDRSIZE   = FIFO_ADDRSIZE,
  parameter int unsigned AFULL_THR  = (32'd1 << ADDRSIZE) - 32'd2,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
`ifdef FIFO_SYNC_ERR_EN
  output logic                woverflow,
  output logic                runderflow,
`endif
  output logic [ADDRSIZE:0]   count
);

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              wr_en, rd_en;
  fifo_flags_t       flags;

  always_comb begin
    flags        = '0;
    flags.empty  = (wptr_q == rptr_q);
    flags.full   = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                   (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
    flags.afull  = 32'(count) >= AFULL_THR;
    flags.aempty = 32'(count) <= AEMPTY_THR;
  end

  // Both requests are qualified by the pre-edge flags; no write-to-read bypass.
  assign wr_en  = winc && !flags.full;
  assign rd_en  = rinc && !flags.empty;
  assign wptr_d = wptr_q + {{ADDRSIZE{1'b0}}, wr_en};
  assign rptr_d = rptr_q + {{ADDRSIZE{1'b0}}, rd_en};

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign count         = wptr_q - rptr_q;
  assign wfull         = flags.full;
  assign rempty        = flags.empty;
  assign walmost_full  = flags.afull;
  assign ralmost_empty = flags.aempty;

`ifdef FIFO_SYNC_ERR_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow  <= 1'b0;
      runderflow <= 1'b0;
    end else begin
      if (winc && flags.full) woverflow <= 1'b1;
      if (rinc && flags.empty) runderflow <= 1'b1;
    end
  end
`endif

  fifo_sync_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .we    (wr_en),
    .waddr (wptr_q[ADDRSIZE-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rptr_q[ADDRSIZE-1:0]),
    .rdata (rdata)
  );

endmodule
